// File: rtl/ctrl_hazard.sv
// ctrl_hazard: merges execute jumps, interrupt vectors and the various stall
// sources into a single hold level and a single pc redirect per cycle.
// Redirects that arrive while the bus is stalled are parked and replayed on
// the first bus-ready cycle.
//
// Handshake: int_req is a level held by the interrupt controller until
// int_ack pulses for one cycle; the ack pulses in the cycle the interrupt
// redirect is actually presented on jump_flag/jump_addr (live or replayed).
module ctrl_hazard #(
    parameter int LU_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_req_i,
    input  logic [31:0] jump_addr_i,
    input  logic        int_req_i,
    input  logic [31:0] int_addr_i,
    input  logic        hold_bus_i,
    input  logic        hold_ex_i,
    input  logic        load_use_i,
    output logic [2:0]  hold_flag_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        int_ack_o,
    output logic        busy_o
);

    localparam logic [2:0] HOLD_NONE = 3'b000;
    localparam logic [2:0] HOLD_IF   = 3'b010;
    localparam logic [2:0] HOLD_ALL  = 3'b011;
    localparam logic [2:0] LU_LOAD   = 3'(LU_CYCLES - 1);

    logic        pend_vld;
    logic        pend_int;
    logic [31:0] pend_addr;
    logic [2:0]  lu_cnt;

    logic window;
    logic issue_int;
    logic issue_pend;
    logic issue_jump;
    logic redirect;
    logic lu_start;
    logic lu_active;

    // Redirect arbitration inside the issue window: live int > pending > live jump.
    always_comb begin
        window     = !hold_bus_i;
        issue_int  = window && int_req_i;
        issue_pend = window && !int_req_i && pend_vld;
        issue_jump = window && !int_req_i && !pend_vld && jump_req_i;
        redirect   = issue_int || issue_pend || issue_jump;
    end

    // Redirect outputs; address is forced to zero when no redirect is issued.
    always_comb begin
        jump_flag_o = redirect;
        jump_addr_o = 32'h0;
        int_ack_o   = 1'b0;
        if (issue_int) begin
            jump_addr_o = int_addr_i;
            int_ack_o   = 1'b1;
        end else if (issue_pend) begin
            jump_addr_o = pend_addr;
            int_ack_o   = pend_int;
        end else if (issue_jump) begin
            jump_addr_o = jump_addr_i;
        end
    end

    // Hold level: bus or divider stall dominates, then any load-use stall.
    always_comb begin
        lu_start  = load_use_i && !redirect;
        lu_active = lu_start || (lu_cnt != 3'd0);
        if (hold_bus_i || hold_ex_i) begin
            hold_flag_o = HOLD_ALL;
        end else if (lu_active) begin
            hold_flag_o = HOLD_IF;
        end else begin
            hold_flag_o = HOLD_NONE;
        end
        busy_o = pend_vld || (lu_cnt != 3'd0);
    end

    // Pending redirect register: capture under bus stall, clear on issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld  <= 1'b0;
            pend_int  <= 1'b0;
            pend_addr <= 32'h0;
        end else if (hold_bus_i) begin
            if (int_req_i) begin
                pend_vld  <= 1'b1;
                pend_int  <= 1'b1;
                pend_addr <= int_addr_i;
            end else if (jump_req_i && !(pend_vld && pend_int)) begin
                pend_vld  <= 1'b1;
                pend_int  <= 1'b0;
                pend_addr <= jump_addr_i;
            end
        end else if (issue_int || issue_pend) begin
            // A live interrupt supersedes any parked ex jump as well.
            pend_vld <= 1'b0;
            pend_int <= 1'b0;
        end
    end

    // Load-use counter: frozen during bus stall, flushed by any redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt <= 3'd0;
        end else if (redirect) begin
            lu_cnt <= 3'd0;
        end else if (hold_bus_i) begin
            lu_cnt <= lu_cnt;
        end else if (load_use_i) begin
            lu_cnt <= LU_LOAD;
        end else if (lu_cnt != 3'd0) begin
            lu_cnt <= lu_cnt - 3'd1;
        end
    end

endmodule

// File: tb/tb_ctrl_hazard.sv
// tb_ctrl_hazard: directed sequence for ctrl_hazard with LU_CYCLES = 3.
// Inputs change 2 time units after each rising edge; outputs are sampled
// 1 unit later, well clear of the next rising edge.
module tb_ctrl_hazard;

    logic        clk;
    logic        rst_n;
    logic        jump_req_i;
    logic [31:0] jump_addr_i;
    logic        int_req_i;
    logic [31:0] int_addr_i;
    logic        hold_bus_i;
    logic        hold_ex_i;
    logic        load_use_i;
    logic [2:0]  hold_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        int_ack_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    ctrl_hazard #(.LU_CYCLES(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .jump_req_i  (jump_req_i),
        .jump_addr_i (jump_addr_i),
        .int_req_i   (int_req_i),
        .int_addr_i  (int_addr_i),
        .hold_bus_i  (hold_bus_i),
        .hold_ex_i   (hold_ex_i),
        .load_use_i  (load_use_i),
        .hold_flag_o (hold_flag_o),
        .jump_flag_o (jump_flag_o),
        .jump_addr_o (jump_addr_o),
        .int_ack_o   (int_ack_o),
        .busy_o      (busy_o)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge, ready to drive inputs.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Compare every output: {hold, jump_flag, jump_addr, int_ack, busy}.
    task automatic check_all(input string tag, input logic [2:0] hold,
                             input logic jf, input logic [31:0] ja,
                             input logic ack, input logic busy);
        logic [37:0] obs;
        logic [37:0] exp;
        #1;
        obs = {hold_flag_o, jump_flag_o, jump_addr_o, int_ack_o, busy_o};
        exp = {hold, jf, ja, ack, busy};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed hold=%b jf=%b addr=%h ack=%b busy=%b expected hold=%b jf=%b addr=%h ack=%b busy=%b",
                   tag, hold_flag_o, jump_flag_o, jump_addr_o, int_ack_o, busy_o,
                   hold, jf, ja, ack, busy);
        end
    endtask

    // Compare only the redirect outputs.
    task automatic check_jump(input string tag, input logic jf, input logic [31:0] ja);
        logic [32:0] obs;
        logic [32:0] exp;
        #1;
        obs = {jump_flag_o, jump_addr_o};
        exp = {jf, ja};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed jf=%b addr=%h expected jf=%b addr=%h",
                   tag, jump_flag_o, jump_addr_o, jf, ja);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        jump_req_i  = 1'b0;
        jump_addr_i = 32'h0;
        int_req_i   = 1'b0;
        int_addr_i  = 32'h0;
        hold_bus_i  = 1'b0;
        hold_ex_i   = 1'b0;
        load_use_i  = 1'b0;

        // Reset state.
        #3;
        check_all("reset", 3'b000, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc();
        cyc();
        rst_n = 1'b1;
        check_all("after_reset", 3'b000, 1'b0, 32'h0, 1'b0, 1'b0);

        // Plain jump, zero latency.
        cyc();
        jump_req_i = 1'b1; jump_addr_i = 32'h0000_0100;
        check_all("plain_jump", 3'b000, 1'b1, 32'h100, 1'b0, 1'b0);
        cyc();
        jump_req_i = 1'b0; jump_addr_i = 32'h0;
        check_all("plain_jump_next", 3'b000, 1'b0, 32'h0, 1'b0, 1'b0);

        // Bus-stalled jump, replayed after release.
        cyc();
        hold_bus_i = 1'b1; jump_req_i = 1'b1; jump_addr_i = 32'h200;
        check_all("bus_c1", 3'b011, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc();
        jump_req_i = 1'b0; jump_addr_i = 32'h0;
        check_all("bus_c2", 3'b011, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc();
        check_all("bus_c3", 3'b011, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc();
        hold_bus_i = 1'b0;
        check_all("bus_c4_issue", 3'b000, 1'b1, 32'h200, 1'b0, 1'b1);
        cyc();
        check_all("bus_c5_idle", 3'b000, 1'b0, 32'h0, 1'b0, 1'b0);

        // Interrupt overrides a parked jump.
        cyc();
        hold_bus_i = 1'b1; jump_req_i = 1'b1; jump_addr_i = 32'h200;
        check_all("ovr_c1", 3'b011, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc();
        jump_req_i = 1'b0; jump_addr_i = 32'h0;
        int_req_i = 1'b1; int_addr_i = 32'h8;
        check_all("ovr_c2", 3'b011, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc();
        hold_bus_i = 1'b0;
        check_all("ovr_issue_int", 3'b000, 1'b1, 32'h8, 1'b1, 1'b1);
        cyc();
        int_req_i = 1'b0; int_addr_i = 32'h0;
        check_all("ovr_no_0x200", 3'b000, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc();
        check_all("ovr_still_idle", 3'b000, 1'b0, 32'h0, 1'b0, 1'b0);

        // A parked interrupt is not overwritten by a later jump.
        cyc();
        hold_bus_i = 1'b1; int_req_i = 1'b1; int_addr_i = 32'h10;
        check_all("pint_c1", 3'b011, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc();
        int_req_i = 1'b0; int_addr_i = 32'h0;
        jump_req_i = 1'b1; jump_addr_i = 32'h300;
        check_all("pint_c2", 3'b011, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc();
        jump_req_i = 1'b0; jump_addr_i = 32'h0; hold_bus_i = 1'b0;
        check_all("pint_issue", 3'b000, 1'b1, 32'h10, 1'b1, 1'b1);
        cyc();
        check_all("pint_idle", 3'b000, 1'b0, 32'h0, 1'b0, 1'b0);

        // Load-use stall of three cycles.
        cyc();
        load_use_i = 1'b1;
        check_all("lu_c1", 3'b010, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc();
        load_use_i = 1'b0;
        check_all("lu_c2", 3'b010, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc();
        check_all("lu_c3", 3'b010, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc();
        check_all("lu_done", 3'b000, 1'b0, 32'h0, 1'b0, 1'b0);

        // Load-use cut short by a jump in its second cycle.
        cyc();
        load_use_i = 1'b1;
        check_all("lujmp_c1", 3'b010, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc();
        load_use_i = 1'b0; jump_req_i = 1'b1; jump_addr_i = 32'h180;
        check_jump("lujmp_c2_jump", 1'b1, 32'h180);
        cyc();
        jump_req_i = 1'b0; jump_addr_i = 32'h0;
        check_all("lujmp_c3_clear", 3'b000, 1'b0, 32'h0, 1'b0, 1'b0);

        // Divider stall does not mask a jump.
        cyc();
        hold_ex_i = 1'b1; jump_req_i = 1'b1; jump_addr_i = 32'h40;
        check_all("div_jump", 3'b011, 1'b1, 32'h40, 1'b0, 1'b0);
        cyc();
        hold_ex_i = 1'b0; jump_req_i = 1'b0; jump_addr_i = 32'h0;
        check_all("div_idle", 3'b000, 1'b0, 32'h0, 1'b0, 1'b0);

        // Reset while a jump is parked discards it.
        cyc();
        hold_bus_i = 1'b1; jump_req_i = 1'b1; jump_addr_i = 32'h500;
        check_all("rstp_c1", 3'b011, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc();
        jump_req_i = 1'b0; jump_addr_i = 32'h0;
        check_all("rstp_parked", 3'b011, 1'b0, 32'h0, 1'b0, 1'b1);
        rst_n = 1'b0;
        check_all("rstp_in_reset", 3'b011, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc();
        rst_n = 1'b1; hold_bus_i = 1'b0;
        check_all("rstp_release", 3'b000, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc();
        check_all("rstp_no_jump", 3'b000, 1'b0, 32'h0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_hazard.md
# ctrl_hazard

Pipeline control unit driving the program counter's `hold_flag_i`, `jump_flag_i` and `jump_addr_i` inputs. It merges jump requests from execute, interrupt vectors, bus stalls, divider stalls and load-use stalls into one hold level and one jump command per cycle. A jump or interrupt that arrives during a bus stall is parked in a pending register and issued once the bus releases, so no redirect is lost. It sits between ex/id/bus/interrupt controller and the pc and pipeline registers.

## Interface
- `LU_CYCLES`, 1, number of cycles a load-use stall holds the front end (1..7)
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous reset, active-low
- `jump_req_i`  in  1  execute-stage branch/jump taken
- `jump_addr_i`  in  32  execute-stage target
- `int_req_i`  in  1  interrupt redirect request (level, held until `int_ack_o`)
- `int_addr_i`  in  32  interrupt vector
- `hold_bus_i`  in  1  bus not ready, whole front end must stall
- `hold_ex_i`  in  1  multi-cycle execute (divider) busy
- `load_use_i`  in  1  id-stage load-use hazard detected (pulse)
- `hold_flag_o`  out  3  hold level: 000 none, 010 hold pc+if_id, 011 hold pc+if_id+id_ex
- `jump_flag_o`  out  1  redirect pc this cycle (also flushes if_id/id_ex)
- `jump_addr_o`  out  32  redirect target, 0 when `jump_flag_o`=0
- `int_ack_o`  out  1  one-cycle pulse: interrupt redirect issued
- `busy_o`  out  1  pending redirect or load-use count outstanding

## Operation
- State: `pend_vld`, `pend_int`, `pend_addr[31:0]`, `lu_cnt[2:0]`. Outputs are Mealy: combinational from state and current inputs; state updates on posedge clk.
- Issue window: `hold_bus_i`=0. Priority inside window: live `int_req_i` > `pend_vld` > live `jump_req_i`.
  - int: `jump_flag_o`=1, `jump_addr_o`=`int_addr_i`, `int_ack_o`=1, clear pending.
  - pending: `jump_flag_o`=1, `jump_addr_o`=`pend_addr`, `int_ack_o`=`pend_int`, clear pending.
  - ex jump: `jump_flag_o`=1, `jump_addr_o`=`jump_addr_i`.
- Outside window (`hold_bus_i`=1): `jump_flag_o`=0. Capture: `int_req_i` → `pend_vld`=1, `pend_int`=1, `pend_addr`=`int_addr_i` (overwrites a pending ex jump). Else `jump_req_i` and not (`pend_vld` & `pend_int`) → `pend_vld`=1, `pend_int`=0, `pend_addr`=`jump_addr_i`. A pending interrupt is never overwritten.
- Load-use: `load_use_i`=1 with no redirect issued this cycle → hold 010 this cycle, `lu_cnt` ← `LU_CYCLES`-1. While `lu_cnt`>0 → hold 010, decrement by 1 each cycle. A redirect issue clears `lu_cnt` to 0 and ignores `load_use_i` in that cycle. During `hold_bus_i`=1, `lu_cnt` freezes.
- `hold_flag_o`: 011 if `hold_bus_i` or `hold_ex_i`; else 010 if load-use active; else 000. A redirect does not mask `hold_ex_i`: the jump and 011 can appear together, and the pc takes the jump.
- `busy_o` = `pend_vld` | (`lu_cnt`≠0).

## Timing
- Reset (async): `pend_vld`=0, `pend_int`=0, `pend_addr`=0, `lu_cnt`=0. With inputs low, all outputs are 0.
- Zero-cycle latency from live request to `jump_flag_o`. The pc samples the output at the next edge.
- Pending redirect issues in the first cycle `hold_bus_i`=0 after capture, exactly once.
- Capture and issue never occur in the same cycle.
- Reset during pending or load-use count discards all state.

## Test plan
- Reset mid-pending: capture jump, then pulse `rst_n` low → `busy_o`=0, no jump after release.
- Plain jump: `jump_req_i`=1, addr 0x0000_0100, no holds → same cycle `jump_flag_o`=1, `jump_addr_o`=0x100, `hold_flag_o`=000. Next cycle all 0.
- Bus-stalled jump: `hold_bus_i`=1 for 3 cycles, jump to 0x200 in cycle 1 → `jump_flag_o`=0 and hold 011 for cycles 1-3. Cycle 4: `jump_flag_o`=1, addr 0x200. Cycle 5: `busy_o`=0.
- Int overrides pending: under bus hold, jump to 0x200, then `int_req_i` with vector 0x8 → on release, a single redirect to 0x8 with `int_ack_o`=1. 0x200 is never issued.
- Load-use with `LU_CYCLES`=3: `load_use_i` pulse → hold 010 for 3 consecutive cycles, then 000. Repeat with `jump_req_i` in the 2nd cycle → jump issued, hold 000 from the next cycle.
- Divider plus jump: `hold_ex_i`=1 with `jump_req_i` to 0x40 → `hold_flag_o`=011 and `jump_flag_o`=1, addr 0x40, in the same cycle.
